// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with write-through and read-old collision.
// Optional registered same-address flag: define DUAL_PORT_RAM_COLLISION_EN.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_b
`ifdef DUAL_PORT_RAM_COLLISION_EN
  ,
  output logic                  collision
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_a;
  logic [DATA_WIDTH-1:0] r_q_b;

  // One block owns the array; port B is written last so it wins a tie.
  // Non-blocking reads see pre-edge contents, giving read-old on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else begin
      if (we_a) begin
        r_mem[addr_a] <= data_a;
        r_q_a         <= data_a;
      end else begin
        r_q_a <= r_mem[addr_a];
      end
      if (we_b) begin
        r_mem[addr_b] <= data_b;
        r_q_b         <= data_b;
      end else begin
        r_q_b <= r_mem[addr_b];
      end
    end
  end

  assign q_a = r_q_a;
  assign q_b = r_q_b;

`ifdef DUAL_PORT_RAM_COLLISION_EN
  logic w_coll;
  logic r_coll;

  assign w_coll = (addr_a == addr_b) && (we_a || we_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_coll;
    end
  end

  assign collision = r_coll;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: driver queues expectations,
// monitor pops one entry per cycle after each rising edge.
module tb_dual_port_ram;

  logic       clk;
  logic       rst;
  logic [7:0] data_a;
  logic [5:0] addr_a;
  logic       we_a;
  logic [7:0] q_a;
  logic [7:0] data_b;
  logic [5:0] addr_b;
  logic       we_b;
  logic [7:0] q_b;
`ifdef DUAL_PORT_RAM_COLLISION_EN
  logic       collision;
`endif

  dual_port_ram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_a(data_a),
    .addr_a(addr_a),
    .we_a(we_a),
    .q_a(q_a),
    .data_b(data_b),
    .addr_b(addr_b),
    .we_b(we_b),
    .q_b(q_b)
`ifdef DUAL_PORT_RAM_COLLISION_EN
    ,
    .collision(collision)
`endif
  );

  typedef struct {
    string      nm;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic op(
    input string      nm,
    input logic       r,
    input logic       wa,
    input logic [5:0] aa,
    input logic [7:0] da,
    input logic       wb,
    input logic [5:0] ab,
    input logic [7:0] db,
    input logic [7:0] ea,
    input logic [7:0] eb,
    input logic       ec
  );
    exp_t e;
    @(negedge clk);
    rst    = r;
    we_a   = wa;
    addr_a = aa;
    data_a = da;
    we_b   = wb;
    addr_b = ab;
    data_b = db;
    e.nm = nm;
    e.ea = ea;
    e.eb = eb;
    e.ec = ec;
    sb.push_back(e);
  endtask

  // Monitor: every rising edge produces one output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q_a !== e.ea) begin
          errors++;
          $display("FAIL %s q_a got %h exp %h", e.nm, q_a, e.ea);
        end
        checks++;
        if (q_b !== e.eb) begin
          errors++;
          $display("FAIL %s q_b got %h exp %h", e.nm, q_b, e.eb);
        end
`ifdef DUAL_PORT_RAM_COLLISION_EN
        checks++;
        if (collision !== e.ec) begin
          errors++;
          $display("FAIL %s collision got %b exp %b",
                   e.nm, collision, e.ec);
        end
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    we_a = 1'b0;
    we_b = 1'b0;
    addr_a = '0;
    addr_b = '0;
    data_a = '0;
    data_b = '0;

    op("rst0", 1, 0, 6'h00, 8'h00, 0, 6'h00, 8'h00, 8'h00, 8'h00, 0);
    // Reset: preload, then reset with writes asserted
    op("pre", 0, 1, 6'h30, 8'h5C, 1, 6'h31, 8'hC3, 8'h5C, 8'hC3, 0);
    op("rstw", 1, 1, 6'h30, 8'hFF, 1, 6'h31, 8'hEE, 8'h00, 8'h00, 0);
    op("rstrb", 0, 0, 6'h30, 8'h00, 0, 6'h31, 8'h00, 8'h5C, 8'hC3, 0);
    // Dual write with write-through
    op("wr1", 0, 1, 6'h01, 8'h12, 1, 6'h02, 8'h15, 8'h12, 8'h15, 0);
    op("wr2", 0, 1, 6'h03, 8'h33, 1, 6'h04, 8'h44, 8'h33, 8'h44, 0);
    // Mixed read/write
    op("mix1", 0, 0, 6'h01, 8'h00, 1, 6'h02, 8'h44, 8'h12, 8'h44, 0);
    op("mix2", 0, 0, 6'h03, 8'h00, 0, 6'h04, 8'h00, 8'h33, 8'h44, 0);
    op("ovr", 0, 0, 6'h02, 8'h00, 0, 6'h02, 8'h00, 8'h44, 8'h44, 0);
    // Cross-port collision: reader sees old data
    op("cx0", 0, 0, 6'h01, 8'h00, 1, 6'h10, 8'h55, 8'h12, 8'h55, 0);
    op("cx1", 0, 1, 6'h10, 8'hAA, 0, 6'h10, 8'h00, 8'hAA, 8'h55, 1);
    op("cx2", 0, 0, 6'h10, 8'h00, 0, 6'h10, 8'h00, 8'hAA, 8'hAA, 0);
    // Same-address dual write: B wins storage
    op("sw1", 0, 1, 6'h20, 8'h11, 1, 6'h20, 8'h22, 8'h11, 8'h22, 1);
    op("sw2", 0, 0, 6'h20, 8'h00, 0, 6'h20, 8'h00, 8'h22, 8'h22, 0);
    // Boundary addresses
    op("bw", 0, 1, 6'h00, 8'hA5, 1, 6'h3F, 8'h5A, 8'hA5, 8'h5A, 0);
    op("br1", 0, 0, 6'h00, 8'h00, 0, 6'h3F, 8'h00, 8'hA5, 8'h5A, 0);
    op("br2", 0, 0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'h5A, 8'hA5, 0);

    @(negedge clk);
    we_a = 1'b0;
    we_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
